// File: rtl/counter_pkg.sv
// Shared counter definitions: the state encoding and the zero-detect helper.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_zero(input logic [31:0] v);
        return (v == 32'd0);
    endfunction

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse, one-shot or auto-reload.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             auto_rld,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             zero,
    output logic             tc_pulse
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             w_tc_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_reload <= '0;
        else if (load)
            r_reload <= cnt_in;
    end

    // Load beats a coincident expiry; outside RUN the count never moves.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tc_nxt    = 1'b0;
        if (load) begin
            w_cnt_nxt   = cnt_in;
            w_state_nxt = is_zero(32'(cnt_in)) ? DONE : RUN;
        end else if (r_state == RUN && enab) begin
            if (r_cnt > WIDTH'(1)) begin
                w_cnt_nxt = r_cnt - WIDTH'(1);
            end else begin
                w_tc_nxt = 1'b1;
                if (auto_rld) begin
                    w_cnt_nxt = r_reload;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end
            end
        end
    end

    assign cnt_out  = r_cnt;
    assign tc_pulse = r_tc;
    assign busy     = (r_state == RUN);
    assign zero     = is_zero(32'(r_cnt));

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer against an arithmetic reference model.
module tb_countdown_timer;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load = 1'b0;
    logic             enab = 1'b0;
    logic             auto_rld = 1'b0;
    logic [WIDTH-1:0] cnt_in = '0;
    logic [WIDTH-1:0] cnt_out;
    logic             busy;
    logic             zero;
    logic             tc_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: count as a plain int, running flag, reload value.
    int m_cnt = 0;
    int m_rld = 0;
    bit m_run = 0;
    bit m_tc  = 0;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .load(load), .enab(enab), .auto_rld(auto_rld),
        .cnt_in(cnt_in), .cnt_out(cnt_out), .busy(busy), .zero(zero),
        .tc_pulse(tc_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".cnt"},  32'(cnt_out),  32'(m_cnt));
        chk({tag, ".busy"}, 32'(busy),     32'(m_run));
        chk({tag, ".zero"}, 32'(zero),     32'(m_cnt == 0));
        chk({tag, ".tc"},   32'(tc_pulse), 32'(m_tc));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_rld = 0; m_run = 0; m_tc = 0;
    endtask

    task automatic model_edge(input bit l, input bit e, input bit a, input int c);
        m_tc = 0;
        if (l) begin
            m_cnt = c; m_rld = c; m_run = (c != 0);
        end else if (m_run && e) begin
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else begin
                m_tc = 1;
                if (a) m_cnt = m_rld;
                else begin m_cnt = 0; m_run = 0; end
            end
        end
    endtask

    // Inputs applied after a negedge, model advanced at posedge, outputs checked at next negedge.
    task automatic step(input string tag, input bit l, input bit e, input bit a, input int c);
        load = l; enab = e; auto_rld = a; cnt_in = WIDTH'(c);
        @(posedge clk);
        model_edge(l, e, a, c);
        @(negedge clk);
        chk_all(tag);
    endtask

    // Reset asserted mid low phase; outputs must clear before any clock edge.
    task automatic mid_reset(input string tag);
        load = 0; enab = 1;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk({tag, ".cnt"},  32'(cnt_out),  32'd0);
        chk({tag, ".busy"}, 32'(busy),     32'd0);
        chk({tag, ".zero"}, 32'(zero),     32'd1);
        chk({tag, ".tc"},   32'(tc_pulse), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_all({tag, ".rel"});
    endtask

    initial begin
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_all("por");
        mid_reset("rst1");

        // One-shot from 3
        step("os.ld", 1, 0, 0, 3);
        repeat (5) step("os.run", 0, 1, 0, 0);
        // Auto-reload with period 2
        step("ar.ld", 1, 1, 1, 2);
        repeat (5) step("ar.run", 0, 1, 1, 0);
        // Hold mid-count from 1F
        step("hd.ld", 1, 0, 0, 31);
        repeat (2) step("hd.en", 0, 1, 0, 0);
        repeat (3) step("hd.hold", 0, 0, 0, 0);
        chk("hd.1D", 32'(cnt_out), 32'h1D);
        // Load coincident with expiry, then load of zero
        step("lx.ld", 1, 0, 0, 2);
        step("lx.en", 0, 1, 0, 0);
        step("lx.ld0A", 1, 1, 0, 10);
        chk("lx.0A", 32'(cnt_out), 32'h0A);
        step("lx.ld00", 1, 1, 0, 0);
        step("lx.done", 0, 1, 1, 0);
        // Reset while running at 0C, then enab alone stays at 0
        step("rr.ld", 1, 0, 0, 12);
        mid_reset("rst2");
        repeat (3) step("rr.idle", 0, 1, 1, 0);
        chk("rr.0", 32'(cnt_out), 32'd0);
        // Reload of 1 gives tc every enabled cycle
        step("r1.ld", 1, 0, 1, 1);
        repeat (3) step("r1.run", 0, 1, 1, 0);

        for (int i = 0; i < 400; i++) begin
            bit l, e, a;
            int c;
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 1);
            c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
            if ($urandom_range(0, 99) == 0) mid_reset("rnd.rst");
            else step("rnd", l, e, a, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
